// File: rtl/lstm_pkg.sv
// ---------------------------------------------------------------------------
// lstm_pkg
// Shared definitions for the LSTM + fully-connected classifier blocks:
//   - sequencer state encoding (IDLE/FEED/WAIT_RES/DONE)
//   - default feature width and frame geometry used by the LSTM/FC datapath
//   - cnt_w(): counter width helper that never returns zero
// ---------------------------------------------------------------------------
package lstm_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FEED     = 2'd1;
    localparam logic [1:0] WAIT_RES = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = IDLE,
        ST_FEED     = FEED,
        ST_WAIT_RES = WAIT_RES,
        ST_DONE     = DONE
    } seq_state_t;

    localparam int DEF_D_WL       = 24;
    localparam int DEF_INPUT_SIZE = 26;
    localparam int DEF_TIME_STEP  = 148;

    // $clog2(n), but at least 1 bit so a degenerate count of 1 still elaborates.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lstm_seq_frame_counter.sv
// ---------------------------------------------------------------------------
// lstm_seq_frame_counter
// Two-level element/step counter walking one frame of INPUT_SIZE x TIME_STEP
// feature words.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   i_clear    in   restart at element 0 of step 0
//   i_advance  in   one feature word accepted this cycle
//   o_last     out  current position is the final word of the frame
// ---------------------------------------------------------------------------
module lstm_seq_frame_counter
    import lstm_pkg::*;
#(
    parameter int INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int TIME_STEP  = DEF_TIME_STEP
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_last
);

    localparam int EW = cnt_w(INPUT_SIZE);
    localparam int SW = cnt_w(TIME_STEP);
    localparam logic [EW-1:0] ELEM_LAST = EW'(INPUT_SIZE - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(TIME_STEP - 1);

    logic [EW-1:0] r_elem;
    logic [SW-1:0] r_step;
    logic          w_elem_wrap;
    logic          w_step_wrap;

    assign w_elem_wrap = (r_elem == ELEM_LAST);
    assign w_step_wrap = (r_step == STEP_LAST);
    assign o_last      = w_elem_wrap & w_step_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elem <= '0;
            r_step <= '0;
        end else if (i_clear) begin
            r_elem <= '0;
            r_step <= '0;
        end else if (i_advance) begin
            if (w_elem_wrap) begin
                r_elem <= '0;
                // Step wraps too so the counter is self-consistent even
                // without an explicit clear between frames.
                r_step <= w_step_wrap ? '0 : r_step + SW'(1);
            end else begin
                r_elem <= r_elem + EW'(1);
            end
        end
    end

endmodule

// File: rtl/lstm_frame_sequencer.sv
// ---------------------------------------------------------------------------
// lstm_frame_sequencer
// Control-plane sequencer for the LSTM + FC classifier. One start pulse runs
// one job: stream INPUT_SIZE x TIME_STEP feature words from the upstream
// valid/ready source into the LSTM (gated by lstm_x_en), wait a bounded time
// for the classifier result, latch it and report done/error status.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     job request, honoured only in IDLE
//   s_valid, s_data, s_ready  upstream feature stream (s_ready combinational)
//   lstm_x_en                 LSTM can admit a feature word this cycle
//   lstm_f_valid/feature      registered feature word to the LSTM
//   lstm_o_valid/result       classifier result pulse and class bit
//   busy, done                status: not idle / one-cycle end-of-job pulse
//   class_out                 class bit of the last successful job
//   err_timeout/err_spurious  sticky error flags, cleared by accepted start
//   frame_cnt                 successful job count (wraps)
// ---------------------------------------------------------------------------
module lstm_frame_sequencer
    import lstm_pkg::*;
#(
    parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
    parameter int TIME_STEP   = DEF_TIME_STEP,
    parameter int D_WL        = DEF_D_WL,
    parameter int TIMEOUT_CYC = 200000,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s_valid,
    input  logic [D_WL-1:0]        s_data,
    output logic                   s_ready,
    input  logic                   lstm_x_en,
    output logic                   lstm_f_valid,
    output logic [D_WL-1:0]        lstm_feature,
    input  logic                   lstm_o_valid,
    input  logic                   lstm_result,
    output logic                   busy,
    output logic                   done,
    output logic                   class_out,
    output logic                   err_timeout,
    output logic                   err_spurious,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    seq_state_t             r_state;
    seq_state_t             w_next;
    logic [TW-1:0]          r_to_cnt;
    logic                   r_f_valid;
    logic [D_WL-1:0]        r_feature;
    logic                   r_class;
    logic                   r_err_to;
    logic                   r_err_sp;
    logic [FRAME_CNT_W-1:0] r_frame;

    logic w_start_acc;
    logic w_xfer;
    logic w_last;
    logic w_to_last;
    logic w_in_wait;

    assign w_in_wait   = (r_state == ST_WAIT_RES);
    assign w_start_acc = (r_state == ST_IDLE) & start;
    assign w_xfer      = s_valid & s_ready;
    assign w_to_last   = (r_to_cnt == TO_LAST);

    lstm_seq_frame_counter #(
        .INPUT_SIZE (INPUT_SIZE),
        .TIME_STEP  (TIME_STEP)
    ) u_frame_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_start_acc),
        .i_advance (w_xfer),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        s_ready = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next = ST_FEED;
            end
            ST_FEED: begin
                s_ready = lstm_x_en;
                if (w_xfer && w_last) w_next = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                // A result on the final timeout cycle still counts as success;
                // the status logic below applies the same priority.
                if (lstm_o_valid || w_to_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Timeout counter: held at zero outside WAIT_RES so it starts from 0 on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (!w_in_wait) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    // Feature output register: one-cycle pass-through, holds between transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_valid <= 1'b0;
            r_feature <= '0;
        end else begin
            r_f_valid <= w_xfer;
            if (w_xfer) r_feature <= s_data;
        end
    end

    // Job status: result capture, completed-frame count, sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_class  <= 1'b0;
            r_frame  <= '0;
            r_err_to <= 1'b0;
            r_err_sp <= 1'b0;
        end else begin
            if (w_in_wait && lstm_o_valid) begin
                r_class <= lstm_result;
                r_frame <= r_frame + FRAME_CNT_W'(1);
            end
            if (w_in_wait && !lstm_o_valid && w_to_last) begin
                r_err_to <= 1'b1;
            end else if (w_start_acc) begin
                r_err_to <= 1'b0;
            end
            // A stray result seen in the same cycle as a start is still reported.
            if (!w_in_wait && lstm_o_valid) begin
                r_err_sp <= 1'b1;
            end else if (w_start_acc) begin
                r_err_sp <= 1'b0;
            end
        end
    end

    assign lstm_f_valid = r_f_valid;
    assign lstm_feature = r_feature;
    assign class_out    = r_class;
    assign frame_cnt    = r_frame;
    assign err_timeout  = r_err_to;
    assign err_spurious = r_err_sp;

endmodule

// File: tb/tb_lstm_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lstm_frame_sequencer
// Directed job sequence with randomized feature data, flow-control gaps and
// result bits, checked against a job-level reference model of the sequencer.
// ---------------------------------------------------------------------------
module tb_lstm_frame_sequencer;

    localparam int IS = 3;
    localparam int TS = 2;
    localparam int NW = IS * TS;
    localparam int TO = 8;
    localparam int DW = 24;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          lstm_x_en = 1'b0;
    logic          lstm_o_valid = 1'b0;
    logic          lstm_result = 1'b0;
    logic          s_ready;
    logic          lstm_f_valid;
    logic [DW-1:0] lstm_feature;
    logic          busy;
    logic          done;
    logic          class_out;
    logic          err_timeout;
    logic          err_spurious;
    logic [FW-1:0] frame_cnt;

    lstm_frame_sequencer #(
        .INPUT_SIZE  (IS),
        .TIME_STEP   (TS),
        .D_WL        (DW),
        .TIMEOUT_CYC (TO),
        .FRAME_CNT_W (FW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .lstm_x_en    (lstm_x_en),
        .lstm_f_valid (lstm_f_valid),
        .lstm_feature (lstm_feature),
        .lstm_o_valid (lstm_o_valid),
        .lstm_result  (lstm_result),
        .busy         (busy),
        .done         (done),
        .class_out    (class_out),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done_seen = 0;
    int n_done_exp  = 0;

    // Reference model of the host-visible status
    logic          m_class = 1'b0;
    logic [FW-1:0] m_frame = '0;
    logic          m_err_to = 1'b0;
    logic          m_err_sp = 1'b0;
    logic [DW-1:0] words[$];

    always @(negedge clk) if (done === 1'b1) n_done_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string pfx);
        chk({pfx, "_class"},  32'(class_out),    32'(m_class));
        chk({pfx, "_frames"}, 32'(frame_cnt),    32'(m_frame));
        chk({pfx, "_err_to"}, 32'(err_timeout),  32'(m_err_to));
        chk({pfx, "_err_sp"}, 32'(err_spurious), 32'(m_err_sp));
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_fvalid"},  32'(lstm_f_valid), 32'd0);
        chk({pfx, "_feature"}, 32'(lstm_feature), 32'd0);
        chk({pfx, "_busy"},    32'(busy),         32'd0);
        chk({pfx, "_done"},    32'(done),         32'd0);
        chk({pfx, "_sready"},  32'(s_ready),      32'd0);
        chk_status(pfx);
    endtask

    // One job, entered and left at posedge+1 in IDLE.
    //   mode       0: s_valid/x_en always 1; 1: x_en alternates 1,0 and s_valid has gaps
    //   start_at   feed cycle carrying a stray start (-1 none)
    //   ov_at      feed cycle carrying a stray lstm_o_valid (-1 none)
    //   abort_after assert rst once this many words have transferred (0 never)
    //   n_res      WAIT_RES cycle (1-based) carrying the result; 0 = never
    //   sid        drive start during the DONE cycle
    task automatic run_job(input string name, input int mode, input int start_at,
                           input int ov_at, input int abort_after, input int n_res,
                           input logic res, input logic sid);
        int sent = 0;
        int cyc = 0;
        int done_cyc;
        logic pv = 1'b0;
        logic [DW-1:0] pw = '0;
        logic aborted = 1'b0;

        words.delete();
        for (int i = 0; i < NW; i++) words.push_back(DW'($urandom));

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_err_to = 1'b0;
        m_err_sp = 1'b0;

        while (sent < NW && cyc < 200) begin
            if (mode == 0) begin
                s_valid = 1'b1;
                lstm_x_en = 1'b1;
            end else begin
                lstm_x_en = (cyc % 2 == 0);
                s_valid = ($urandom % 3 != 0);
            end
            s_data = s_valid ? words[sent] : DW'($urandom);
            start = (cyc == start_at);
            lstm_o_valid = (cyc == ov_at);
            lstm_result = 1'($urandom);
            @(negedge clk);
            if (cyc == 0) begin
                chk({name, "_start_clr_err_to"}, 32'(err_timeout),  32'd0);
                chk({name, "_start_clr_err_sp"}, 32'(err_spurious), 32'd0);
            end
            chk({name, "_sready_feed"}, 32'(s_ready),      32'(lstm_x_en));
            chk({name, "_fvalid_feed"}, 32'(lstm_f_valid), 32'(pv));
            if (pv) chk({name, "_feature"}, 32'(lstm_feature), 32'(pw));
            chk({name, "_busy_feed"},   32'(busy),         32'd1);
            if (cyc == ov_at) m_err_sp = 1'b1;
            pv = s_valid & lstm_x_en;
            if (pv) begin
                pw = words[sent];
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (abort_after > 0 && sent == abort_after) begin
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        lstm_o_valid = 1'b0;

        if (aborted) begin
            rst = 1'b1;
            #1;
            m_class = 1'b0;
            m_frame = '0;
            m_err_to = 1'b0;
            m_err_sp = 1'b0;
            chk_all_zero({name, "_async_rst"});
            s_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk); #1;
            return;
        end
        chk({name, "_feed_words"}, 32'(sent), 32'(NW));

        done_cyc = (n_res >= 1 && n_res <= TO) ? n_res + 1 : TO + 1;
        for (int j = 1; j <= done_cyc; j++) begin
            s_valid = 1'($urandom);
            lstm_x_en = 1'($urandom);
            s_data = DW'($urandom);
            lstm_o_valid = (j == n_res);
            lstm_result = res;
            start = (j == done_cyc) ? sid : 1'($urandom);
            @(negedge clk);
            if (j == 1) begin
                chk({name, "_fvalid_lastword"}, 32'(lstm_f_valid), 32'd1);
                chk({name, "_lastword"},        32'(lstm_feature), 32'(pw));
            end else begin
                chk({name, "_fvalid_wait"},     32'(lstm_f_valid), 32'd0);
            end
            chk({name, "_sready_wait"}, 32'(s_ready), 32'd0);
            chk({name, "_done_timing"}, 32'(done),    32'(j == done_cyc));
            chk({name, "_busy_wait"},   32'(busy),    32'd1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        lstm_o_valid = 1'b0;
        s_valid = 1'b0;

        if (n_res >= 1 && n_res <= TO) begin
            m_class = res;
            m_frame = m_frame + FW'(1);
        end else begin
            m_err_to = 1'b1;
        end
        n_done_exp++;

        @(negedge clk);
        chk({name, "_done_after"}, 32'(done), 32'd0);
        chk({name, "_idle_after"}, 32'(busy), 32'd0);
        chk_status(name);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean job, result 1 five cycles after the last word
        run_job("full",     0, -1, -1, 0, 5, 1'b1, 1'b0);
        // Admission toggling with upstream gaps
        run_job("xen_tgl",  1, -1, -1, 0, 3, 1'b1, 1'b0);
        // Timeout; a start during DONE must be ignored
        run_job("timeout",  0, -1, -1, 0, 0, 1'b0, 1'b1);
        // Result coincides with the final timeout cycle
        run_job("coincide", 0, -1, -1, 0, TO, 1'b0, 1'b0);
        // Stray start and stray result while feeding
        run_job("spurious", 1, 2, 4, 0, 2, 1'b1, 1'b0);
        // Reset after four words, then a complete fresh job
        run_job("abort",    0, -1, -1, 4, 0, 1'b0, 1'b0);
        run_job("post_rst", 0, -1, -1, 0, 1, 1'($urandom), 1'b0);

        chk("done_pulse_count", 32'(n_done_seen), 32'(n_done_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
